// File: rtl/hept_stage_sequencer_if.sv
// Handshake bundle between the HEPT stage sequencer, the myproject top
// above it, and the four kernel sub-stages below it.
//   ap_start/ap_done/ap_ready/ap_idle : upward ap_ctrl_hs interface
//   st_start/st_ready/st_done         : per-stage ap_ctrl_hs, bit 0 = tq,
//                                       1 = tk, 2 = dist, 3 = norm
// slave  : sequencer view
// master : view of the block driving ap_start and emulating the stages
interface hept_stage_sequencer_if;
    logic       ap_start;
    logic       ap_done;
    logic       ap_ready;
    logic       ap_idle;
    logic [3:0] st_start;
    logic [3:0] st_ready;
    logic [3:0] st_done;

    modport master (
        output ap_start,
        input  ap_done,
        input  ap_ready,
        input  ap_idle,
        input  st_start,
        output st_ready,
        output st_done
    );

    modport slave (
        input  ap_start,
        output ap_done,
        output ap_ready,
        output ap_idle,
        output st_start,
        input  st_ready,
        input  st_done
    );
endinterface

// File: rtl/hept_stage_sequencer.sv
// Sequences the HEPT kernel sub-stages (transpose Q, transpose K,
// pairwise_dist_sq_rbf, mask_and_normalize) over their ap_ctrl_hs
// handshakes, records per-stage cycle counts and watches each stage for
// a hang.
// Ports:
//   ap_clk, ap_rst_n   clock, async active-low reset
//   ctl                handshake bundle (slave view)
//   timeout_cycles     watchdog limit, 0 disables
//   err_clr            leave ERR back to IDLE
//   err, err_stage     ERR flag and index of the stage that timed out
//   cyc_tq..cyc_norm   latched cycle count of the last run of each stage
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for ap_start, ap_idle high
// TQ    | stage 0 (transpose Q) running
// TK    | stage 1 (transpose K) running
// DIST  | stage 2 (pairwise_dist_sq_rbf) running
// NORM  | stage 3 (mask_and_normalize) running
// DONE  | one-cycle ap_done/ap_ready pulse
// ERR   | a stage hit the watchdog limit, waiting for err_clr
module hept_stage_sequencer #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT_EN = 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    hept_stage_sequencer_if.slave ctl,
    input  logic [CNT_W-1:0]     timeout_cycles,
    input  logic                 err_clr,
    output logic                 err,
    output logic [1:0]           err_stage,
    output logic [CNT_W-1:0]     cyc_tq,
    output logic [CNT_W-1:0]     cyc_tk,
    output logic [CNT_W-1:0]     cyc_dist,
    output logic [CNT_W-1:0]     cyc_norm
);

    localparam bit               WD_ON   = (TIMEOUT_EN != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TQ,
        S_TK,
        S_DIST,
        S_NORM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_nxt, stage_nxt;
    logic             in_stage;
    logic [1:0]       idx;
    logic             stage_done;
    logic             wd_hit;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cyc_r [4];
    logic [3:0]       st_start_c;
    logic [1:0]       err_stage_r;

    // Which stage is active and which state follows it.
    always_comb begin
        in_stage  = 1'b0;
        idx       = 2'd0;
        stage_nxt = S_IDLE;
        case (state)
            S_TQ:   begin in_stage = 1'b1; idx = 2'd0; stage_nxt = S_TK;   end
            S_TK:   begin in_stage = 1'b1; idx = 2'd1; stage_nxt = S_DIST; end
            S_DIST: begin in_stage = 1'b1; idx = 2'd2; stage_nxt = S_NORM; end
            S_NORM: begin in_stage = 1'b1; idx = 2'd3; stage_nxt = S_DONE; end
            default: ;
        endcase
    end

    assign stage_done = in_stage && ctl.st_done[idx];

    // A done arriving on the limit cycle takes priority over the timeout.
    assign wd_hit = WD_ON && in_stage && (timeout_cycles != '0)
                    && (cnt == timeout_cycles) && !stage_done;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        st_start_c = '0;
        case (state)
            S_IDLE: begin
                if (ctl.ap_start) state_nxt = S_TQ;
            end
            S_TQ, S_TK, S_DIST, S_NORM: begin
                st_start_c[idx] = !acc;
                if (stage_done)  state_nxt = stage_nxt;
                else if (wd_hit) state_nxt = S_ERR;
            end
            S_DONE: state_nxt = S_IDLE;
            S_ERR: begin
                if (err_clr) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counter is loaded with 1 on entry so the first stage cycle counts
    // as 1 and the done cycle is included in the latched value.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc         <= 1'b0;
            cnt         <= '0;
            err_stage_r <= 2'd0;
            for (int i = 0; i < 4; i++) cyc_r[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    acc <= 1'b0;
                    cnt <= ctl.ap_start ? CNT_ONE : '0;
                end
                S_TQ, S_TK, S_DIST, S_NORM: begin
                    if (stage_done) begin
                        cyc_r[idx] <= cnt;
                        acc        <= 1'b0;
                        cnt        <= (state == S_NORM) ? '0 : CNT_ONE;
                    end else begin
                        if (st_start_c[idx] && ctl.st_ready[idx]) acc <= 1'b1;
                        if (cnt != '1) cnt <= cnt + CNT_ONE;
                        if (wd_hit) err_stage_r <= idx;
                    end
                end
                default: begin
                    acc <= 1'b0;
                    cnt <= '0;
                end
            endcase
        end
    end

    assign ctl.st_start = st_start_c;
    assign ctl.ap_idle  = (state == S_IDLE);
    assign ctl.ap_done  = (state == S_DONE);
    assign ctl.ap_ready = (state == S_DONE);
    assign err          = WD_ON && (state == S_ERR);
    assign err_stage    = err_stage_r;
    assign cyc_tq       = cyc_r[0];
    assign cyc_tk       = cyc_r[1];
    assign cyc_dist     = cyc_r[2];
    assign cyc_norm     = cyc_r[3];

endmodule

// File: tb/tb_hept_stage_sequencer.sv
module tb_hept_stage_sequencer;

    localparam int CNT_W = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic [CNT_W-1:0] timeout_cycles = '0;
    logic             err_clr = 1'b0;
    logic             err;
    logic [1:0]       err_stage;
    logic [CNT_W-1:0] cyc_tq, cyc_tk, cyc_dist, cyc_norm;

    hept_stage_sequencer_if ifc ();

    hept_stage_sequencer #(.CNT_W(CNT_W), .TIMEOUT_EN(1)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .ctl            (ifc),
        .timeout_cycles (timeout_cycles),
        .err_clr        (err_clr),
        .err            (err),
        .err_stage      (err_stage),
        .cyc_tq         (cyc_tq),
        .cyc_tk         (cyc_tk),
        .cyc_dist       (cyc_dist),
        .cyc_norm       (cyc_norm)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    // stage emulation: ready rdly cycles after first start cycle,
    // done ddly cycles after ready, never done when hang is set
    int         rdly [4];
    int         ddly [4];
    logic [3:0] hang = '0;
    logic [3:0] stray_ready = '0;
    logic [3:0] stray_done = '0;

    int         obs_first [4];
    int         obs_high [4];
    int         obs_done, obs_ready, obs_err;
    logic [1:0] obs_err_stage;

    initial begin
        logic [3:0] busy;
        logic [3:0] r, d;
        int         k [4];
        busy = '0;
        ifc.st_ready = '0;
        ifc.st_done  = '0;
        forever begin
            @(negedge ap_clk);
            #1;
            r = '0;
            d = '0;
            if (!ap_rst_n) begin
                busy = '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!busy[i] && ifc.st_start[i]) begin
                        busy[i] = 1'b1;
                        k[i] = 0;
                    end
                    if (busy[i]) begin
                        r[i] = (k[i] == rdly[i]);
                        d[i] = !hang[i] && (k[i] == rdly[i] + ddly[i]);
                        if (d[i]) busy[i] = 1'b0;
                        k[i]++;
                    end
                end
            end
            ifc.st_ready = r | stray_ready;
            ifc.st_done  = d | stray_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic set_stages(input int rd, input int dd);
        for (int i = 0; i < 4; i++) begin
            rdly[i] = rd;
            ddly[i] = dd;
        end
        hang = '0;
    endtask

    task automatic apply_reset();
        @(negedge ap_clk);
        ap_rst_n       = 1'b0;
        ifc.ap_start   = 1'b0;
        err_clr        = 1'b0;
        stray_ready    = '0;
        stray_done     = '0;
        timeout_cycles = '0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    // Pulses ap_start at the current negedge (cycle 0) and records when
    // things happen, in cycles after that.
    task automatic run_seq(input int budget, input int stray_until);
        for (int b = 0; b < 4; b++) begin
            obs_first[b] = -1;
            obs_high[b]  = 0;
        end
        obs_done  = -1;
        obs_ready = -1;
        obs_err   = -1;
        obs_err_stage = 2'd0;
        ifc.ap_start = 1'b1;
        for (int j = 1; j <= budget; j++) begin
            @(negedge ap_clk);
            if (j == 1) ifc.ap_start = 1'b0;
            if (j > stray_until) begin
                stray_ready = '0;
                stray_done  = '0;
            end
            for (int b = 0; b < 4; b++) begin
                if (ifc.st_start[b]) begin
                    if (obs_first[b] < 0) obs_first[b] = j;
                    obs_high[b]++;
                end
            end
            if (ifc.ap_ready && obs_ready < 0) obs_ready = j;
            if (ifc.ap_done) begin
                obs_done = j;
                break;
            end
            if (err) begin
                obs_err = j;
                obs_err_stage = err_stage;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ifc.ap_start = 1'b0;
        #1;
        total++; if (ifc.ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", ifc.ap_idle); end
        total++; if (ifc.st_start !== 4'b0) begin bad++; $display("FAIL reset_st_start: got %b want 0000", ifc.st_start); end
        total++; if (ifc.ap_done !== 1'b0 || ifc.ap_ready !== 1'b0) begin bad++; $display("FAIL reset_done_ready: got %b%b want 00", ifc.ap_done, ifc.ap_ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (err_stage !== 2'd0) begin bad++; $display("FAIL reset_err_stage: got %0d want 0", err_stage); end
        total++; if ({cyc_tq, cyc_tk, cyc_dist, cyc_norm} !== '0) begin bad++; $display("FAIL reset_cyc: got %0d %0d %0d %0d want 0 0 0 0", cyc_tq, cyc_tk, cyc_dist, cyc_norm); end
        apply_reset();
    endtask

    task automatic test_nominal();
        apply_reset();
        set_stages(0, 3);
        run_seq(40, 0);
        for (int b = 0; b < 4; b++) begin
            total++; if (obs_first[b] != 1 + 4 * b) begin bad++; $display("FAIL nominal_start%0d: got cycle %0d want %0d", b, obs_first[b], 1 + 4 * b); end
            total++; if (obs_high[b] != 1) begin bad++; $display("FAIL nominal_start_len%0d: got %0d want 1", b, obs_high[b]); end
        end
        total++; if (obs_done != 17) begin bad++; $display("FAIL nominal_done: got cycle %0d want 17", obs_done); end
        total++; if (obs_ready != 17) begin bad++; $display("FAIL nominal_ready: got cycle %0d want 17", obs_ready); end
        total++; if (cyc_tq !== 16'd4 || cyc_tk !== 16'd4 || cyc_dist !== 16'd4 || cyc_norm !== 16'd4) begin bad++; $display("FAIL nominal_cyc: got %0d %0d %0d %0d want 4 4 4 4", cyc_tq, cyc_tk, cyc_dist, cyc_norm); end
        @(negedge ap_clk);
        total++; if (ifc.ap_done !== 1'b0 || ifc.ap_idle !== 1'b1) begin bad++; $display("FAIL nominal_after_done: got done=%b idle=%b want done=0 idle=1", ifc.ap_done, ifc.ap_idle); end
    endtask

    task automatic test_stray();
        apply_reset();
        set_stages(0, 3);
        stray_ready = 4'hF;
        stray_done  = 4'hF;
        for (int j = 0; j < 3; j++) begin
            @(negedge ap_clk);
            total++; if (ifc.ap_idle !== 1'b1 || ifc.st_start !== 4'b0) begin bad++; $display("FAIL stray_idle: got idle=%b st_start=%b want idle=1 st_start=0000", ifc.ap_idle, ifc.st_start); end
        end
        stray_ready = 4'b1110;
        stray_done  = 4'b1110;
        run_seq(40, 3);
        total++; if (obs_first[1] != 5) begin bad++; $display("FAIL stray_tk_start: got cycle %0d want 5", obs_first[1]); end
        total++; if (obs_done != 17) begin bad++; $display("FAIL stray_done: got cycle %0d want 17", obs_done); end
        total++; if (cyc_tq !== 16'd4) begin bad++; $display("FAIL stray_cyc_tq: got %0d want 4", cyc_tq); end
    endtask

    task automatic test_delayed_ready();
        apply_reset();
        set_stages(0, 3);
        rdly[2] = 5;
        ddly[2] = 2;
        run_seq(40, 0);
        total++; if (obs_high[2] != 6) begin bad++; $display("FAIL delayed_start_len: got %0d want 6", obs_high[2]); end
        total++; if (cyc_dist !== 16'd8) begin bad++; $display("FAIL delayed_cyc_dist: got %0d want 8", cyc_dist); end
        total++; if (obs_first[3] != 17) begin bad++; $display("FAIL delayed_norm_start: got cycle %0d want 17", obs_first[3]); end
        total++; if (obs_done != 21) begin bad++; $display("FAIL delayed_done: got cycle %0d want 21", obs_done); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        set_stages(0, 3);
        ddly[3] = 0;
        run_seq(40, 0);
        total++; if (cyc_norm !== 16'd1) begin bad++; $display("FAIL same_cycle_cyc_norm: got %0d want 1", cyc_norm); end
        total++; if (obs_done != 14) begin bad++; $display("FAIL same_cycle_done: got cycle %0d want 14", obs_done); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        set_stages(0, 3);
        hang[1] = 1'b1;
        timeout_cycles = 16'd10;
        run_seq(40, 0);
        total++; if (obs_err != 15) begin bad++; $display("FAIL wd_err_cycle: got cycle %0d want 15", obs_err); end
        total++; if (obs_err_stage !== 2'd1) begin bad++; $display("FAIL wd_err_stage: got %0d want 1", obs_err_stage); end
        total++; if (cyc_tq !== 16'd4 || cyc_tk !== 16'd0) begin bad++; $display("FAIL wd_cyc: got tq=%0d tk=%0d want tq=4 tk=0", cyc_tq, cyc_tk); end
        ifc.ap_start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge ap_clk);
            total++; if (err !== 1'b1 || ifc.st_start !== 4'b0 || ifc.ap_idle !== 1'b0) begin bad++; $display("FAIL wd_hold: got err=%b st_start=%b idle=%b want err=1 st_start=0000 idle=0", err, ifc.st_start, ifc.ap_idle); end
        end
        ifc.ap_start = 1'b0;
        err_clr = 1'b1;
        @(negedge ap_clk);
        err_clr = 1'b0;
        total++; if (ifc.ap_idle !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL wd_clear: got idle=%b err=%b want idle=1 err=0", ifc.ap_idle, err); end
        total++; if (err_stage !== 2'd1) begin bad++; $display("FAIL wd_err_stage_kept: got %0d want 1", err_stage); end
    endtask

    task automatic test_done_beats_timeout();
        apply_reset();
        set_stages(0, 3);
        ddly[0] = 5;
        timeout_cycles = 16'd6;
        run_seq(40, 0);
        total++; if (obs_err != -1) begin bad++; $display("FAIL beat_no_err: got err at cycle %0d want none", obs_err); end
        total++; if (cyc_tq !== 16'd6) begin bad++; $display("FAIL beat_cyc_tq: got %0d want 6", cyc_tq); end
        total++; if (obs_done != 19) begin bad++; $display("FAIL beat_done: got cycle %0d want 19", obs_done); end
        timeout_cycles = '0;
    endtask

    task automatic test_back_to_back();
        int j;
        apply_reset();
        set_stages(0, 3);
        run_seq(40, 0);
        total++; if (obs_done != 17) begin bad++; $display("FAIL b2b_first_done: got cycle %0d want 17", obs_done); end
        ifc.ap_start = 1'b1;
        @(negedge ap_clk);
        total++; if (ifc.ap_idle !== 1'b1 || ifc.st_start !== 4'b0) begin bad++; $display("FAIL b2b_idle_gap: got idle=%b st_start=%b want idle=1 st_start=0000", ifc.ap_idle, ifc.st_start); end
        @(negedge ap_clk);
        ifc.ap_start = 1'b0;
        total++; if (ifc.st_start !== 4'b0001) begin bad++; $display("FAIL b2b_restart: got st_start=%b want 0001", ifc.st_start); end
        j = 1;
        while (j < 40 && ifc.ap_done !== 1'b1) begin
            @(negedge ap_clk);
            j++;
        end
        total++; if (j != 17) begin bad++; $display("FAIL b2b_second_done: got cycle %0d want 17", j); end
    endtask

    task automatic test_reset_mid_run();
        int j;
        apply_reset();
        set_stages(0, 3);
        ifc.ap_start = 1'b1;
        j = 0;
        do begin
            @(negedge ap_clk);
            ifc.ap_start = 1'b0;
            j++;
        end while (j < 30 && ifc.st_start[2] !== 1'b1);
        total++; if (j != 9) begin bad++; $display("FAIL midrst_reach_dist: got cycle %0d want 9", j); end
        @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        total++; if (ifc.st_start !== 4'b0 || ifc.ap_idle !== 1'b1) begin bad++; $display("FAIL midrst_async: got st_start=%b idle=%b want st_start=0000 idle=1", ifc.st_start, ifc.ap_idle); end
        total++; if ({cyc_tq, cyc_tk, cyc_dist, cyc_norm} !== '0) begin bad++; $display("FAIL midrst_cyc: got %0d %0d %0d %0d want 0 0 0 0", cyc_tq, cyc_tk, cyc_dist, cyc_norm); end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_seq(40, 0);
        total++; if (obs_first[0] != 1 || obs_done != 17) begin bad++; $display("FAIL midrst_rerun: got tq_start=%0d done=%0d want 1 and 17", obs_first[0], obs_done); end
        total++; if (cyc_dist !== 16'd4) begin bad++; $display("FAIL midrst_cyc_dist: got %0d want 4", cyc_dist); end
    endtask

    initial begin
        ifc.ap_start = 1'b0;
        set_stages(0, 3);
        test_reset();
        test_nominal();
        test_stray();
        test_delayed_ready();
        test_same_cycle();
        test_watchdog();
        test_done_beats_timeout();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hept_stage_sequencer.md
Name: hept_stage_sequencer

Overview:
- Control FSM that sequences the HEPT kernel sub-stages in fixed order, each over its ap_ctrl_hs start/ready/done handshake: transpose Q, transpose K, pairwise_dist_sq_rbf, mask_and_normalize.
- Presents a single ap_ctrl_hs interface upward to the myproject top.
- Records per-stage cycle counts for the profiling flow.
- Provides a per-stage watchdog that flags a hung stage.

Parameters:
- CNT_W, 16, width of each per-stage cycle counter and of timeout_cycles.
- TIMEOUT_EN, 1, 1 = watchdog enabled; 0 = watchdog logic removed and err tied to 0.

Ports:
- ap_clk  in  1  single clock for all logic.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  top start request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse when all four stages are complete.
- ap_ready  out  1  one-cycle pulse, same cycle as ap_done.
- ap_idle  out  1  high in IDLE only.
- st_start  out  4  per-stage start; bit 0 = tq, 1 = tk, 2 = dist, 3 = norm.
- st_ready  in  4  per-stage ap_ready.
- st_done  in  4  per-stage ap_done.
- timeout_cycles  in  CNT_W  watchdog limit, static while running; 0 disables the watchdog.
- err_clr  in  1  clears ERR state.
- err  out  1  high while in ERR.
- err_stage  out  2  index of the stage that timed out.
- cyc_tq, cyc_tk, cyc_dist, cyc_norm  out  CNT_W each  latched cycle count of the last run of each stage.

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE, ap_idle = 1.
  - All other outputs 0, including cycle registers and err_stage.
  - Reset mid-run abandons the sequence. Stages are not flushed; the top also resets them.
- States: IDLE, TQ, TK, DIST, NORM, DONE, ERR. All transitions on rising ap_clk.
- IDLE:
  - ap_start = 1 → TQ next cycle.
  - Clears per-stage accept flag and running counter.
- Stage states (S = TQ/TK/DIST/NORM, index i = 0..3):
  - st_start[i] = (state == S) && !acc. Combinational from registers; all other st_start bits are 0.
  - acc sets when st_start[i] && st_ready[i] are sampled together. st_start drops the cycle after ready.
  - st_done[i] is honoured only in S. It may arrive in the same cycle as st_ready[i] (acc irrelevant).
  - On st_done[i]: latch count into cyc_*, advance to next state, clear acc and counter.
  - Order: TQ→TK→DIST→NORM→DONE.
  - Stage i+1 start rises exactly 1 cycle after stage i done. Sequencer overhead is 1 cycle per stage boundary.
- Cycle count:
  - Counter starts at 1 in the first cycle of S and increments every cycle in S.
  - Latched value includes the done cycle. A stage with done in its first cycle records 1.
  - Saturates at 2^CNT_W−1, no wrap.
- Watchdog (TIMEOUT_EN = 1, timeout_cycles ≠ 0):
  - If counter == timeout_cycles and st_done[i] = 0 → ERR next cycle, err_stage = i.
  - Done in the same cycle as the limit wins: normal advance, no error.
- ERR:
  - err = 1; all st_start bits 0; ap_start ignored.
  - err_clr = 1 → IDLE next cycle; err_stage is retained until the next error or reset.
- DONE:
  - ap_done = ap_ready = 1 for exactly 1 cycle → IDLE.
  - ap_start high in DONE is ignored; it is re-sampled in IDLE the next cycle.
  - Back-to-back runs cost 1 IDLE cycle.
- Out-of-state handshakes:
  - Stray st_done/st_ready on non-active stages are ignored.
  - ap_idle = 0 in every non-IDLE state, including ERR.

Test Plan:
- Nominal run:
  - Stimulus: ap_start pulse at t0. Each stage asserts ready with its first start cycle and done 3 cycles later.
  - Response: st_start bit 0 high at t0+1, bit 1 at t0+5, bit 2 at t0+9, bit 3 at t0+13. ap_done/ap_ready at t0+17. All cyc_* = 4.
- Delayed ready:
  - Stimulus: dist ready held off 5 cycles, then done 2 cycles after ready.
  - Response: st_start[2] high 6 cycles, drops the cycle after ready. cyc_dist = 8.
- Same-cycle ready+done:
  - Stimulus: norm asserts ready and done in its first cycle.
  - Response: cyc_norm = 1; DONE next cycle.
- Watchdog:
  - Stimulus: timeout_cycles = 10; tk never asserts done.
  - Response: err = 1 and err_stage = 1 on the cycle after count 10. st_start = 0. ap_start ignored.
  - err_clr returns to IDLE with ap_idle = 1.
- Done beats timeout:
  - Stimulus: timeout_cycles = 6; tq done at count 6.
  - Response: no err, cyc_tq = 6.
- Reset mid-run:
  - Stimulus: ap_rst_n low during DIST.
  - Response: immediately (async) st_start = 0, ap_idle = 1, all cyc_* = 0. A fresh ap_start runs cleanly from TQ.
